// File: rtl/comparador_serie_izq_der.sv
// Serial MSB-first magnitude comparator: one bit pair of A and B per accepted cycle.
// A three-state control FSM and an absorbing IGUAL/MAYOR/MENOR tracker. All outputs are registered.
module comparador_serie_izq_der #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   bit_valid,
  input  logic                   a_bit,
  input  logic                   b_bit,
  output logic                   busy,
  output logic                   done,
  output logic                   z,
  output logic                   a_mayor,
  output logic                   a_menor,
  output logic                   iguales,
  output logic [$clog2(N+1)-1:0] bit_count
);
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [1:0] {IGUAL, MAYOR, MENOR} cmp_t;

  state_t state;
  cmp_t   cmp, cmp_nxt;
  logic   last_bit;

  // The first differing bit decides the result. After that, cmp stays put.
  always_comb begin
    cmp_nxt = cmp;
    if (cmp == IGUAL && a_bit != b_bit)
      cmp_nxt = a_bit ? MAYOR : MENOR;
  end

  assign last_bit = (bit_count == CW'(N-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmp       <= IGUAL;
      busy      <= 1'b0;
      done      <= 1'b0;
      z         <= 1'b0;
      a_mayor   <= 1'b0;
      a_menor   <= 1'b0;
      iguales   <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= 1'b0;
      // If start arrives with a valid pair in the same cycle, start takes
      // priority and that pair is dropped. This also aborts a word in progress.
      if (start) begin
        state     <= RUN;
        busy      <= 1'b1;
        cmp       <= IGUAL;
        bit_count <= '0;
      end else begin
        case (state)
          RUN: begin
            if (bit_valid) begin
              cmp       <= cmp_nxt;
              bit_count <= bit_count + CW'(1);
              if (last_bit) begin
                state   <= FIN;
                busy    <= 1'b0;
                done    <= 1'b1;
                a_mayor <= (cmp_nxt == MAYOR);
                a_menor <= (cmp_nxt == MENOR);
                iguales <= (cmp_nxt == IGUAL);
                z       <= (cmp_nxt != MENOR);
              end
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comparador_serie_izq_der.sv
// Directed bench for comparador_serie_izq_der. Expected results are queued at start
// and popped by a monitor on each done pulse.
module tb_comparador_serie_izq_der;
  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic busy, done, z, a_mayor, a_menor, iguales;
  logic [CW-1:0] bit_count;
  logic [3:0] res;

  int checks = 0, errors = 0, dones = 0;
  logic [3:0] exp_q[$];
  logic [3:0] held_res = 4'b0000;

  comparador_serie_izq_der #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done), .z(z),
    .a_mayor(a_mayor), .a_menor(a_menor), .iguales(iguales),
    .bit_count(bit_count)
  );

  assign res = {z, a_mayor, a_menor, iguales};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {z, a_mayor, a_menor, iguales} from plain integer comparison
  function automatic logic [3:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a > b)      return 4'b1100;
    else if (a < b) return 4'b0010;
    else            return 4'b1001;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      dones++;
      chk("sb_nonempty_on_done", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_result", 32'(res), 32'(exp_q.pop_front()));
    end
  end

  task automatic pulse_start(input logic v, input logic ab, input logic bb);
    start = 1'b1; bit_valid = v; a_bit = ab; b_bit = bb;
    tick;
    start = 1'b0; bit_valid = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("count_cleared", 32'(bit_count), 32'd0);
  endtask

  task automatic feed(input logic [N-1:0] a, input logic [N-1:0] b,
                      input int hi, input int lo, input bit gap);
    for (int i = hi; i >= lo; i--) begin
      if (gap) begin bit_valid = 1'b0; tick; end
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      tick;
    end
    bit_valid = 1'b0;
  endtask

  task automatic word(input logic [N-1:0] a, input logic [N-1:0] b,
                      input bit gap, input bit discard);
    logic [3:0] e;
    e = model(a, b);
    exp_q.push_back(e);
    pulse_start(discard, 1'b0, 1'b1);
    feed(a, b, N-1, 1, gap);
    chk("count_before_last", 32'(bit_count), 32'(N-1));
    chk("no_early_done", 32'(done), 32'd0);
    chk("result_held", 32'(res), 32'(held_res));
    feed(a, b, 0, 0, gap);
    chk("done_at_latency", 32'(done), 32'd1);
    chk("busy_at_fin", 32'(busy), 32'd0);
    chk("result", 32'(res), 32'(e));
    chk("count_at_fin", 32'(bit_count), 32'(N));
    held_res = e;
    tick;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("count_holds", 32'(bit_count), 32'(N));
  endtask

  initial begin
    tick; tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_count", 32'(bit_count), 32'd0);
    reset = 1'b0;
    tick;

    word(8'hA5, 8'h5A, 1'b0, 1'b0);
    word(8'h3C, 8'h3C, 1'b0, 1'b0);
    word(8'h00, 8'hFF, 1'b0, 1'b0);
    word(8'h80, 8'h7F, 1'b1, 1'b0);
    word(8'h01, 8'h00, 1'b0, 1'b1);

    // abort after 4 bits; the restarted word must be the only done
    pulse_start(1'b0, 1'b0, 1'b0);
    feed(8'hFF, 8'h00, N-1, N-4, 1'b0);
    chk("abort_count", 32'(bit_count), 32'd4);
    chk("abort_res_held", 32'(res), 32'(held_res));
    word(8'h10, 8'h20, 1'b0, 1'b0);

    // reset mid-word clears everything without waiting for a clock edge
    pulse_start(1'b0, 1'b0, 1'b0);
    feed(8'hFF, 8'h00, N-1, N-3, 1'b0);
    chk("pre_reset_count", 32'(bit_count), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_rst_res", 32'(res), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_count", 32'(bit_count), 32'd0);
    tick;
    reset = 1'b0;
    held_res = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'b1; a_bit = 1'($urandom_range(1)); b_bit = 1'($urandom_range(1));
      tick;
    end
    bit_valid = 1'b0;
    tick;
    chk("idle_count", 32'(bit_count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_res", 32'(res), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("done_total", 32'(dones), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
